// File: rtl/jk_cmd_sequencer.sv
// jk_cmd_sequencer: takes a (op, count) command and replays it as count
// enable cycles on a downstream JK flip-flop. It keeps a model of the
// flop's Q, compares that model against the fed-back q_in when the command
// finishes, and holds a sticky err flag if the two ever disagree.
//
// Command timeline, counted from the accept edge:
//   count > 0 : cycles 1..count       RUN, enable=1, {J,K}=op
//               cycle  count+1        RUN, enable=0 (q_in settles)
//               cycle  count+2        CHECK, done=1
//   count = 0 : cycle  1              CHECK, done=1
// The next command can be accepted in the cycle after CHECK.
module jk_cmd_sequencer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_async_n,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             cmd_ready,
    input  logic             q_in,
    input  logic             clear_err,
    output logic             J,
    output logic             K,
    output logic             enable,
    output logic             q_model,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Next Q of a JK flop for a given {J,K}: hold, clear, set, toggle.
    function automatic logic jk_next(input logic q, input logic [1:0] jk);
        logic r;
        case (jk)
            2'b00:   r = q;
            2'b01:   r = 1'b0;
            2'b10:   r = 1'b1;
            2'b11:   r = ~q;
            default: r = q;
        endcase
        return r;
    endfunction

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r,   cnt_s;
    logic [1:0]       op_r,    op_s;
    logic             en_r,    en_s;
    logic             j_r,     j_s;
    logic             k_r,     k_s;
    logic             qm_r,    qm_s;
    logic             busy_r,  busy_s;
    logic             done_r,  done_s;
    logic             err_r,   err_s;
    logic             ready_r, ready_s;

    // Next-state and next-output logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        op_s    = op_r;
        en_s    = 1'b0;
        j_s     = 1'b0;
        k_s     = 1'b0;
        qm_s    = qm_r;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        err_s   = err_r;
        ready_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                ready_s = 1'b1;
                if (clear_err) begin
                    err_s = 1'b0;
                end else begin
                    err_s = err_r;
                end
                // ready_r gates the accept so that nothing is taken in the
                // first cycle after reset release.
                if (cmd_valid && ready_r) begin
                    op_s    = cmd_op;
                    cnt_s   = cmd_count;
                    ready_s = 1'b0;
                    busy_s  = 1'b1;
                    if (cmd_count != CNT_ZERO) begin
                        state_s = ST_RUN;
                        en_s    = 1'b1;
                        j_s     = cmd_op[1];
                        k_s     = cmd_op[0];
                    end else begin
                        state_s = ST_CHECK;
                        done_s  = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                busy_s = 1'b1;
                if (en_r) begin
                    // The downstream flop samples J/K on this edge, so the model does too.
                    qm_s    = jk_next(qm_r, op_r);
                    cnt_s   = cnt_r - CNT_ONE;
                    state_s = ST_RUN;
                    if (cnt_r > CNT_ONE) begin
                        en_s = 1'b1;
                        j_s  = op_r[1];
                        k_s  = op_r[0];
                    end else begin
                        en_s = 1'b0;
                    end
                end else begin
                    state_s = ST_CHECK;
                    done_s  = 1'b1;
                end
            end
            ST_CHECK: begin
                state_s = ST_IDLE;
                ready_s = 1'b1;
                // A mismatch wins over clear_err, which is ignored here anyway.
                if (q_in != qm_r) begin
                    err_s = 1'b1;
                end else begin
                    err_s = err_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything, including cmd_ready.
    always_ff @(posedge clk or negedge reset_async_n) begin
        if (!reset_async_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            op_r    <= 2'b00;
            en_r    <= 1'b0;
            j_r     <= 1'b0;
            k_r     <= 1'b0;
            qm_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            ready_r <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            op_r    <= op_s;
            en_r    <= en_s;
            j_r     <= j_s;
            k_r     <= k_s;
            qm_r    <= qm_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            err_r   <= err_s;
            ready_r <= ready_s;
        end
    end

    assign cmd_ready = ready_r;
    assign J         = j_r;
    assign K         = k_r;
    assign enable    = en_r;
    assign q_model   = qm_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Scoreboard bench for jk_cmd_sequencer: the stimulus pushes hand-computed
// expectations, and a negedge monitor pops and checks them on every done pulse.
module tb_jk_cmd_sequencer;

    logic       clk;
    logic       reset_async_n;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic [3:0] cmd_count;
    logic       cmd_ready;
    logic       q_in;
    logic       clear_err;
    logic       J, K, enable, q_model, busy, done, err;

    jk_cmd_sequencer #(.CNT_W(4)) dut (
        .clk           (clk),
        .reset_async_n (reset_async_n),
        .cmd_valid     (cmd_valid),
        .cmd_op        (cmd_op),
        .cmd_count     (cmd_count),
        .cmd_ready     (cmd_ready),
        .q_in          (q_in),
        .clear_err     (clear_err),
        .J             (J),
        .K             (K),
        .enable        (enable),
        .q_model       (q_model),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream JK flip-flop model; q_in can be forced to 0.
    logic ff_q;
    logic force_q0;
    always @(posedge clk or negedge reset_async_n) begin
        if (!reset_async_n) ff_q <= 1'b0;
        else if (enable) begin
            case ({J, K})
                2'b01:   ff_q <= 1'b0;
                2'b10:   ff_q <= 1'b1;
                2'b11:   ff_q <= ~ff_q;
                default: ff_q <= ff_q;
            endcase
        end
    end
    assign q_in = force_q0 ? 1'b0 : ff_q;

    typedef struct {
        logic [1:0] op;
        int         en;
        logic       q;
        logic       e;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_done  = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    // Monitor state
    int         cyc = 0;
    int         since = 0, busy_cnt = 0, en_cnt = 0, jk_bad = 0;
    int         done_cyc = -100, last_gap = 0;
    logic       tracking = 1'b0;
    logic       err_pend = 1'b0;
    logic       exp_err = 1'b0;
    logic [1:0] cur_op = 2'b00;

    // Monitor: counts per-command activity and checks it against the scoreboard on done.
    always @(negedge clk) begin
        exp_t it;
        if (!reset_async_n) begin
            tracking = 1'b0;
            err_pend = 1'b0;
        end else begin
            if (err_pend) begin
                chk("err_after_check", err, exp_err);
                err_pend = 1'b0;
            end
            if (tracking) begin
                since++;
                if (busy) busy_cnt++;
                if (enable) begin
                    en_cnt++;
                    if ({J, K} != cur_op) jk_bad++;
                end
            end
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", done, 0);
                end else begin
                    it = sb.pop_front();
                    chk("done_latency", since, it.lat);
                    chk("enable_cycles", en_cnt, it.en);
                    chk("jk_drive_bad_cycles", jk_bad, 0);
                    chk("busy_cycles", busy_cnt, it.lat);
                    chk("q_model", q_model, it.q);
                    exp_err  = it.e;
                    err_pend = 1'b1;
                    n_done++;
                end
                tracking = 1'b0;
                done_cyc = cyc;
            end
            if (cmd_valid && cmd_ready) begin
                tracking = 1'b1;
                since    = 0;
                busy_cnt = 0;
                en_cnt   = 0;
                jk_bad   = 0;
                cur_op   = cmd_op;
                last_gap = cyc - done_cyc;
            end
            cyc++;
        end
    end

    // Push the expectation, then hold cmd_valid until the accept edge.
    task automatic send(input logic [1:0] op, input logic [3:0] cnt,
                        input logic exp_q, input logic exp_e, input int lat);
        exp_t it;
        bit   acc;
        it.op = op; it.en = int'(cnt); it.q = exp_q; it.e = exp_e; it.lat = lat;
        sb.push_back(it);
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_count = cnt;
        acc = 1'b0;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            if (cmd_ready) acc = 1'b1;
        end
        if (!acc) chk("accept_timeout", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Wait for the n-th done pulse, then one more negedge for the err check.
    task automatic wait_done(input int target);
        for (int i = 0; i < 200 && n_done < target; i++) @(negedge clk);
        if (n_done < target) chk("done_timeout", n_done, target);
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 0);
        chk({tag, "_enable"},    enable,    0);
        chk({tag, "_J"},         J,         0);
        chk({tag, "_K"},         K,         0);
        chk({tag, "_q_model"},   q_model,   0);
        chk({tag, "_busy"},      busy,      0);
        chk({tag, "_done"},      done,      0);
        chk({tag, "_err"},       err,       0);
    endtask

    initial begin
        reset_async_n = 1'b0;
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_count = 4'd0;
        clear_err = 1'b0; force_q0 = 1'b0;
        #2;
        chk_all_zero("reset");
        #20;
        reset_async_n = 1'b1;
        #1;
        chk("ready_before_first_edge", cmd_ready, 0);
        @(posedge clk); #1;
        chk("ready_after_first_edge", cmd_ready, 1);

        // set x1 from Q=0
        send(2'b10, 4'd1, 1'b1, 1'b0, 3);
        wait_done(1);
        // clear x1
        send(2'b01, 4'd1, 1'b0, 1'b0, 3);
        wait_done(2);
        // toggle x5 from Q=0
        send(2'b11, 4'd5, 1'b1, 1'b0, 7);
        wait_done(3);
        // hold x0: straight to CHECK
        send(2'b00, 4'd0, 1'b1, 1'b0, 1);
        wait_done(4);
        // set x2 with q_in stuck at 0 -> err
        force_q0 = 1'b1;
        send(2'b10, 4'd2, 1'b1, 1'b1, 4);
        wait_done(5);
        force_q0 = 1'b0;
        // toggle x3, clear_err pulsed during RUN must be ignored
        send(2'b11, 4'd3, 1'b0, 1'b1, 5);
        clear_err = 1'b1;
        @(posedge clk); #1;
        clear_err = 1'b0;
        wait_done(6);
        // clear_err in IDLE clears err
        @(posedge clk); #1;
        clear_err = 1'b1;
        @(posedge clk); #1;
        clear_err = 1'b0;
        @(negedge clk);
        chk("err_cleared_in_idle", err, 0);
        // toggle x15 then back-to-back clear x1
        send(2'b11, 4'd15, 1'b1, 1'b0, 17);
        send(2'b01, 4'd1, 1'b0, 1'b0, 3);
        chk("back_to_back_gap", last_gap, 1);
        wait_done(8);

        // toggle x8 interrupted by reset in cycle 3
        send(2'b11, 4'd8, 1'b1, 1'b0, 10);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("enable_before_reset", enable, 1);
        #2;
        reset_async_n = 1'b0;
        #1;
        chk_all_zero("midrun_reset");
        sb.delete();
        @(posedge clk);
        @(negedge clk); #1;
        reset_async_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("no_done_after_abort", n_done, 8);
        // next command starts from q_model=0
        send(2'b11, 4'd1, 1'b1, 1'b0, 3);
        wait_done(9);
        send(2'b00, 4'd2, 1'b1, 1'b0, 4);
        wait_done(10);
        chk("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d done pulses seen", n_done);
        $fatal(1, "watchdog");
    end

endmodule
